sprite_layer_renderer: RTL and testbench
========================================

SPRITE_LAYER_RENDERER -- requirements
Module: sprite_layer_renderer

Interface
REQ-001: Parameter SPR_W, default 32, sprite width in texels (power of two, 8..64).
REQ-002: Parameter SPR_H, default 32, sprite height in texels (power of two, 8..64).
REQ-003: Parameter SCALE_SH, default 0, texel-to-pixel upscale as a left shift (0..2, i.e. x1/x2/x4).
REQ-004: Parameter NUM_FRAMES, default 4, animation frames stored back-to-back in ROM (1..16).
REQ-005: Parameter ROM_LAT, default 1, external ROM read latency in cycles (1..2).
REQ-006: Parameter TRANSP_IDX, default 4'h0, palette index treated as transparent.
REQ-007: Parameter ANIM_DIV, default 8, frames-per-animation-step when auto-animating (1..255).
REQ-008: vga_clk  in  1  sole clock; all logic on the rising edge.
REQ-009: Reset  in  1  synchronous, active-high reset.
REQ-010: DrawX, DrawY  in  10 each  current scan coordinate.
REQ-011: blank  in  1  high = active video (display enabled).
REQ-012: pos_x, pos_y  in  10 each  sprite top-left in screen pixels.
REQ-013: spr_en  in  1  sprite visible.
REQ-014: anim_en  in  1  1 = auto-advance frames; 0 = use frame_sel.
REQ-015: frame_sel  in  4  manual frame index.
REQ-016: bg_red, bg_green, bg_blue  in  4 each  background pixel for the same DrawX/DrawY.
REQ-017: rom_address  out  clog2(NUM_FRAMES*SPR_W*SPR_H)  registered ROM address.
REQ-018: rom_q  in  4  palette index returned ROM_LAT cycles after rom_address.
REQ-019: pal_index  out  4  palette lookup index (combinational palette external).
REQ-020: pal_red, pal_green, pal_blue  in  4 each  palette colour for pal_index.
REQ-021: red, green, blue  out  4 each  registered final pixel.
REQ-022: hit  out  1  registered; current output pixel is an opaque sprite texel.

Function
REQ-023: Frame start SHALL be the cycle DrawX==0 and DrawY==0.
REQ-024: pos_x, pos_y, spr_en SHALL be latched only at frame start; mid-frame changes SHALL not affect the current frame.
REQ-025: Frame index: anim_en=0 -> latched at frame start from frame_sel, clamped to NUM_FRAMES-1 when frame_sel >= NUM_FRAMES.
REQ-026: anim_en=1 -> an 8-bit frame-start counter SHALL count to ANIM_DIV-1, then clear and advance the frame index, wrapping from NUM_FRAMES-1 to 0.
REQ-027: Switching anim_en 1->0 SHALL reload frame_sel at the next frame start; 0->1 SHALL start stepping from the current index with the counter cleared.
REQ-028: Stage 1: relX = DrawX - pos_x, relY = DrawY - pos_y computed 11-bit signed; inbox = spr_en & relX,relY >= 0 & relX < SPR_W<<SCALE_SH & relY < SPR_H<<SCALE_SH.
REQ-029: rom_address SHALL register frame*SPR_W*SPR_H + (relY>>SCALE_SH)*SPR_W + (relX>>SCALE_SH) when inbox, else 0.
REQ-030: pal_index SHALL equal rom_q directly.
REQ-031: inbox, blank and bg_* SHALL be delayed through shift registers matching ROM_LAT so they align with rom_q.
REQ-032: Output stage: if delayed blank==0 -> RGB=0, hit=0; else if delayed inbox and rom_q != TRANSP_IDX -> RGB=pal_*, hit=1; else RGB=bg_* (delayed), hit=0.
REQ-033: Total latency DrawX/DrawY/blank/bg_* -> red/green/blue/hit SHALL be exactly ROM_LAT+2 cycles, fixed regardless of inbox.
REQ-034: Sprites extending past x=639 or y=479 SHALL be clipped implicitly (no wrap to left/top edges).

Reset
REQ-035: Reset SHALL clear red, green, blue, hit, rom_address, all delay registers, frame index and animation counter to 0, and latched pos_x/pos_y/spr_en to 0.
REQ-036: Reset asserted mid-frame SHALL force outputs to 0 within one cycle; the sprite SHALL not appear until the first frame start after Reset deasserts.

Verification
REQ-037: Defaults, pos=(100,50), spr_en=1, ROM texel (0,0) index 5 -> at DrawX=100,DrawY=50, rom_address=0 one cycle later, RGB=palette[5], hit=1 three cycles after.
REQ-038: SCALE_SH=1, pos=(0,0) -> DrawX=2,3 both read rom_address 1; DrawX=64 is outside box, RGB=bg_*, hit=0.
REQ-039: Texel index == TRANSP_IDX inside box -> RGB equals delayed bg_*, hit=0; blank=0 anywhere -> RGB=0.
REQ-040: anim_en=1, ANIM_DIV=2, NUM_FRAMES=4 -> frame index 0,0,1,1,2,2,3,3,0 over nine frame starts; frame_sel=9 with anim_en=0 -> frame 3 (address base 3072).
REQ-041: Change pos_x mid-frame from 100 to 300 -> current frame still drawn at 100; next frame at 300.
REQ-042: Assert Reset at DrawY=200 for 3 cycles -> outputs 0 next cycle; sprite absent until following frame start, then reappears correctly.

Source files
------------

// File: rtl/sprite_layer_renderer.sv
// sprite_layer_renderer
//   Overlays one animated sprite, read from an external texel ROM, onto a
//   background pixel stream. DrawX/DrawY/blank/bg_* enter at the scan rate, and
//   red/green/blue/hit leave exactly ROM_LAT+2 cycles later.
//
// Ports
//   vga_clk                      sole clock, rising edge
//   Reset                        synchronous, active-high
//   DrawX, DrawY                 current scan coordinate
//   blank                        1 = active video
//   pos_x, pos_y, spr_en         sprite placement (sampled at frame start)
//   anim_en, frame_sel           auto-animate or manual frame select
//   bg_red/green/blue            background pixel for the same coordinate
//   rom_address / rom_q          registered ROM address / palette index back
//   pal_index / pal_red/green/blue  external combinational palette
//   red, green, blue, hit        registered final pixel, hit = opaque texel
module sprite_layer_renderer #(
  parameter int         SPR_W      = 32,
  parameter int         SPR_H      = 32,
  parameter int         SCALE_SH   = 0,
  parameter int         NUM_FRAMES = 4,
  parameter int         ROM_LAT    = 1,
  parameter logic [3:0] TRANSP_IDX = 4'h0,
  parameter int         ANIM_DIV   = 8
) (
  input  logic                                         vga_clk,
  input  logic                                         Reset,
  input  logic [9:0]                                   DrawX,
  input  logic [9:0]                                   DrawY,
  input  logic                                         blank,
  input  logic [9:0]                                   pos_x,
  input  logic [9:0]                                   pos_y,
  input  logic                                         spr_en,
  input  logic                                         anim_en,
  input  logic [3:0]                                   frame_sel,
  input  logic [3:0]                                   bg_red,
  input  logic [3:0]                                   bg_green,
  input  logic [3:0]                                   bg_blue,
  output logic [$clog2(NUM_FRAMES*SPR_W*SPR_H)-1:0]    rom_address,
  input  logic [3:0]                                   rom_q,
  output logic [3:0]                                   pal_index,
  input  logic [3:0]                                   pal_red,
  input  logic [3:0]                                   pal_green,
  input  logic [3:0]                                   pal_blue,
  output logic [3:0]                                   red,
  output logic [3:0]                                   green,
  output logic [3:0]                                   blue,
  output logic                                         hit
);

  localparam int         ADDR_W     = $clog2(NUM_FRAMES * SPR_W * SPR_H);
  // side-band signals must wait one cycle for the address register plus ROM_LAT
  localparam int         DLY        = ROM_LAT + 1;
  localparam int         BOX_W      = SPR_W << SCALE_SH;
  localparam int         BOX_H      = SPR_H << SCALE_SH;
  localparam logic [3:0] LAST_FRAME = 4'(NUM_FRAMES - 1);
  localparam logic [7:0] CNT_TOP    = 8'(ANIM_DIV - 1);

  logic [9:0]              pos_x_q, pos_x_d;
  logic [9:0]              pos_y_q, pos_y_d;
  logic                    spr_en_q, spr_en_d;
  logic [3:0]              frame_q, frame_d;               // animation index
  logic [3:0]              render_frame_q, render_frame_d; // frame drawn now
  logic [7:0]              anim_cnt_q, anim_cnt_d;
  logic [ADDR_W-1:0]       rom_address_q, rom_address_d;
  logic [DLY-1:0]          inbox_dly_q, inbox_dly_d;
  logic [DLY-1:0]          blank_dly_q, blank_dly_d;
  logic [DLY-1:0][11:0]    bg_dly_q, bg_dly_d;
  logic [11:0]             rgb_q, rgb_d;
  logic                    hit_q, hit_d;

  logic                    frame_start_s;
  logic [3:0]              sel_clamped_s;
  logic [10:0]             rel_x_s, rel_y_s;
  logic                    inbox_s;
  logic [ADDR_W-1:0]       addr_s;

  // Frame-start latching of placement and frame index, plus animation stepping.
  always_comb begin
    frame_start_s  = (DrawX == 10'd0) && (DrawY == 10'd0);
    sel_clamped_s  = frame_sel;
    pos_x_d        = pos_x_q;
    pos_y_d        = pos_y_q;
    spr_en_d       = spr_en_q;
    frame_d        = frame_q;
    render_frame_d = render_frame_q;
    anim_cnt_d     = anim_cnt_q;
    // widen by one bit so NUM_FRAMES=16 does not wrap to zero
    if ({1'b0, frame_sel} >= 5'(NUM_FRAMES)) begin
      sel_clamped_s = LAST_FRAME;
    end else begin
      sel_clamped_s = frame_sel;
    end
    if (frame_start_s) begin
      pos_x_d  = pos_x;
      pos_y_d  = pos_y;
      spr_en_d = spr_en;
      if (anim_en) begin
        // draw the current index; the step takes effect for the next frame
        render_frame_d = frame_q;
        if (anim_cnt_q == CNT_TOP) begin
          anim_cnt_d = 8'd0;
          if (frame_q == LAST_FRAME) begin
            frame_d = 4'd0;
          end else begin
            frame_d = frame_q + 4'd1;
          end
        end else begin
          anim_cnt_d = anim_cnt_q + 8'd1;
        end
      end else begin
        // manual mode parks the counter at zero so re-enabling starts clean
        render_frame_d = sel_clamped_s;
        frame_d        = sel_clamped_s;
        anim_cnt_d     = 8'd0;
      end
    end else begin
      pos_x_d = pos_x_q;
    end
  end

  // Stage 1: box test and texel address. The _d placement values equal the
  // latched ones except on the frame-start cycle, where the new values apply.
  always_comb begin
    rel_x_s = {1'b0, DrawX} - {1'b0, pos_x_d};
    rel_y_s = {1'b0, DrawY} - {1'b0, pos_y_d};
    inbox_s = spr_en_d && !rel_x_s[10] && !rel_y_s[10] &&
              (rel_x_s < 11'(BOX_W)) && (rel_y_s < 11'(BOX_H));
    addr_s  = ADDR_W'(render_frame_d) * ADDR_W'(SPR_W * SPR_H) +
              ADDR_W'(rel_y_s[9:0] >> SCALE_SH) * ADDR_W'(SPR_W) +
              ADDR_W'(rel_x_s[9:0] >> SCALE_SH);
    if (inbox_s) begin
      rom_address_d = addr_s;
    end else begin
      rom_address_d = {ADDR_W{1'b0}};
    end
  end

  // Delay lines that keep box/blank/background aligned with rom_q.
  always_comb begin
    inbox_dly_d = {inbox_dly_q[DLY-2:0], inbox_s};
    blank_dly_d = {blank_dly_q[DLY-2:0], blank};
    bg_dly_d    = {bg_dly_q[DLY-2:0], bg_red, bg_green, bg_blue};
  end

  // Output select: blanking wins, then opaque sprite texel, then background.
  always_comb begin
    rgb_d = 12'h000;
    hit_d = 1'b0;
    if (!blank_dly_q[DLY-1]) begin
      rgb_d = 12'h000;
      hit_d = 1'b0;
    end else if (inbox_dly_q[DLY-1] && (rom_q != TRANSP_IDX)) begin
      rgb_d = {pal_red, pal_green, pal_blue};
      hit_d = 1'b1;
    end else begin
      rgb_d = bg_dly_q[DLY-1];
      hit_d = 1'b0;
    end
  end

  // State and pipeline registers with synchronous reset.
  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      pos_x_q        <= 10'd0;
      pos_y_q        <= 10'd0;
      spr_en_q       <= 1'b0;
      frame_q        <= 4'd0;
      render_frame_q <= 4'd0;
      anim_cnt_q     <= 8'd0;
      rom_address_q  <= {ADDR_W{1'b0}};
      inbox_dly_q    <= {DLY{1'b0}};
      blank_dly_q    <= {DLY{1'b0}};
      bg_dly_q       <= {DLY{12'h000}};
      rgb_q          <= 12'h000;
      hit_q          <= 1'b0;
    end else begin
      pos_x_q        <= pos_x_d;
      pos_y_q        <= pos_y_d;
      spr_en_q       <= spr_en_d;
      frame_q        <= frame_d;
      render_frame_q <= render_frame_d;
      anim_cnt_q     <= anim_cnt_d;
      rom_address_q  <= rom_address_d;
      inbox_dly_q    <= inbox_dly_d;
      blank_dly_q    <= blank_dly_d;
      bg_dly_q       <= bg_dly_d;
      rgb_q          <= rgb_d;
      hit_q          <= hit_d;
    end
  end

  assign rom_address = rom_address_q;
  assign pal_index   = rom_q;
  assign red         = rgb_q[11:8];
  assign green       = rgb_q[7:4];
  assign blue        = rgb_q[3:0];
  assign hit         = hit_q;

endmodule

// File: tb/tb_sprite_layer_renderer.sv
// Bench for sprite_layer_renderer: two instances share stimulus.
//   u0: defaults (ROM_LAT=1, x1 scale, ANIM_DIV=8)
//   u1: SCALE_SH=1, ROM_LAT=2, ANIM_DIV=2
// A frame-level model predicts every registered output each cycle.
module tb_sprite_layer_renderer;

  logic vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  logic       Reset, blank, spr_en, anim_en;
  logic [9:0] DrawX, DrawY, pos_x, pos_y;
  logic [3:0] frame_sel, bg_red, bg_green, bg_blue;

  logic [11:0] rom_address0, rom_address1;
  logic [3:0]  rom_q0, rom_q1, pal_index0, pal_index1;
  logic [3:0]  pal_red0, pal_green0, pal_blue0, pal_red1, pal_green1, pal_blue1;
  logic [3:0]  red0, green0, blue0, red1, green1, blue1;
  logic        hit0, hit1;

  logic [3:0] rom [4096];
  logic [3:0] rq0 = 4'd0, rq1a = 4'd0, rq1b = 4'd0;

  int n_tests = 0;
  int n_fail  = 0;

  function automatic logic [3:0] pal_r(input logic [3:0] i); return i ^ 4'h3; endfunction
  function automatic logic [3:0] pal_g(input logic [3:0] i); return i + 4'h7; endfunction
  function automatic logic [3:0] pal_b(input logic [3:0] i); return ~i;       endfunction

  assign pal_red0 = pal_r(pal_index0); assign pal_green0 = pal_g(pal_index0); assign pal_blue0 = pal_b(pal_index0);
  assign pal_red1 = pal_r(pal_index1); assign pal_green1 = pal_g(pal_index1); assign pal_blue1 = pal_b(pal_index1);

  // external synchronous ROMs with 1 and 2 cycles of latency
  always @(posedge vga_clk) begin
    rq0  <= rom[rom_address0];
    rq1a <= rom[rom_address1];
    rq1b <= rq1a;
  end
  assign rom_q0 = rq0;
  assign rom_q1 = rq1b;

  sprite_layer_renderer u0 (
    .vga_clk(vga_clk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
    .pos_x(pos_x), .pos_y(pos_y), .spr_en(spr_en), .anim_en(anim_en), .frame_sel(frame_sel),
    .bg_red(bg_red), .bg_green(bg_green), .bg_blue(bg_blue),
    .rom_address(rom_address0), .rom_q(rom_q0), .pal_index(pal_index0),
    .pal_red(pal_red0), .pal_green(pal_green0), .pal_blue(pal_blue0),
    .red(red0), .green(green0), .blue(blue0), .hit(hit0)
  );

  sprite_layer_renderer #(.SCALE_SH(1), .ROM_LAT(2), .ANIM_DIV(2)) u1 (
    .vga_clk(vga_clk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
    .pos_x(pos_x), .pos_y(pos_y), .spr_en(spr_en), .anim_en(anim_en), .frame_sel(frame_sel),
    .bg_red(bg_red), .bg_green(bg_green), .bg_blue(bg_blue),
    .rom_address(rom_address1), .rom_q(rom_q1), .pal_index(pal_index1),
    .pal_red(pal_red1), .pal_green(pal_green1), .pal_blue(pal_blue1),
    .red(red1), .green(green1), .blue(blue1), .hit(hit1)
  );

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_px[2], m_py[2], m_en[2], m_fidx[2], m_cnt[2], m_rf[2];
  logic [12:0] q0[$];
  logic [12:0] q1[$];
  logic [12:0] exp_pix[2];
  logic [11:0] exp_addr[2];
  bit model_live = 1'b0;

  task automatic model_edge(input int i, output logic [12:0] pix, output logic [11:0] addr);
    int sh, div, rx, ry, bw, a;
    bit inbox;
    logic [3:0] tex;
    sh = (i == 0) ? 0 : 1;
    div = (i == 0) ? 8 : 2;
    pix = 13'd0; addr = 12'd0; tex = 4'd0; inbox = 1'b0;
    if (Reset) begin
      m_px[i] = 0; m_py[i] = 0; m_en[i] = 0; m_fidx[i] = 0; m_cnt[i] = 0; m_rf[i] = 0;
    end else begin
      if (DrawX == 10'd0 && DrawY == 10'd0) begin
        m_px[i] = int'(pos_x); m_py[i] = int'(pos_y); m_en[i] = int'(spr_en);
        if (anim_en) begin
          m_rf[i] = m_fidx[i];
          m_cnt[i]++;
          if (m_cnt[i] == div) begin
            m_cnt[i] = 0;
            m_fidx[i] = (m_fidx[i] + 1) % 4;
          end
        end else begin
          m_rf[i] = (int'(frame_sel) > 3) ? 3 : int'(frame_sel);
          m_fidx[i] = m_rf[i];
          m_cnt[i] = 0;
        end
      end
      rx = int'(DrawX) - m_px[i];
      ry = int'(DrawY) - m_py[i];
      bw = 32 << sh;
      inbox = (m_en[i] != 0) && rx >= 0 && ry >= 0 && rx < bw && ry < bw;
      if (inbox) begin
        a = m_rf[i] * 1024 + (ry >> sh) * 32 + (rx >> sh);
        addr = 12'(a);
        tex = rom[a];
      end
      if (!blank) pix = 13'd0;
      else if (inbox && tex != 4'h0) pix = {1'b1, pal_r(tex), pal_g(tex), pal_b(tex)};
      else pix = {1'b0, bg_red, bg_green, bg_blue};
    end
  endtask

  // model: one evaluation per rising edge, delayed by the pipeline depth
  initial begin
    logic [12:0] p;
    logic [11:0] a;
    repeat (2) q0.push_back(13'd0);
    repeat (3) q1.push_back(13'd0);
    forever begin
      @(posedge vga_clk);
      if (Reset) model_live = 1'b1;
      for (int i = 0; i < 2; i++) begin
        model_edge(i, p, a);
        exp_addr[i] = a;
        if (i == 0) begin
          if (Reset) foreach (q0[k]) q0[k] = 13'd0;
          q0.push_back(p);
          exp_pix[0] = q0.pop_front();
        end else begin
          if (Reset) foreach (q1[k]) q1[k] = 13'd0;
          q1.push_back(p);
          exp_pix[1] = q1.pop_front();
        end
      end
    end
  end

  // compare process on the falling edge
  initial begin
    forever begin
      @(negedge vga_clk);
      if (model_live) begin
        chk("pix0", {hit0, red0, green0, blue0}, exp_pix[0]);
        chk("pix1", {hit1, red1, green1, blue1}, exp_pix[1]);
        chk("addr0", rom_address0, exp_addr[0]);
        chk("addr1", rom_address1, exp_addr[1]);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge vga_clk);
    #1;
  endtask

  task automatic put(input int x, input int y);
    DrawX = 10'(x);
    DrawY = 10'(y);
    tick();
  endtask

  initial begin
    int fx, fy, x, y;
    int anim_exp[9];
    anim_exp = '{0, 0, 1024, 1024, 2048, 2048, 3072, 3072, 0};
    for (int k = 0; k < 4096; k++) rom[k] = 4'($urandom_range(0, 15));
    rom[0] = 4'h5;
    rom[2] = 4'h0;
    Reset = 1'b1; blank = 1'b0; spr_en = 1'b0; anim_en = 1'b0; frame_sel = 4'd0;
    DrawX = 10'd5; DrawY = 10'd5; pos_x = 10'd0; pos_y = 10'd0;
    bg_red = 4'd0; bg_green = 4'd0; bg_blue = 4'd0;
    repeat (3) tick();
    chk("reset_pix0", {hit0, red0, green0, blue0}, 13'h0000);
    chk("reset_addr1", rom_address1, 12'd0);
    Reset = 1'b0;

    // sprite at (100,50): opaque texel, transparent texel, blanking
    pos_x = 10'd100; pos_y = 10'd50; spr_en = 1'b1; blank = 1'b1;
    put(0, 0);
    bg_red = 4'h1; bg_green = 4'h1; bg_blue = 4'h1;
    put(100, 50); chk("d1_addr_first", rom_address0, 12'd0);
    put(101, 50); chk("d1_addr_next", rom_address0, 12'd1);
    bg_red = 4'h7; bg_green = 4'h8; bg_blue = 4'h9;
    put(102, 50); chk("d1_opaque_pix", {hit0, red0, green0, blue0}, 13'h16CA);
    bg_red = 4'h2; bg_green = 4'h2; bg_blue = 4'h2;
    put(103, 50);
    blank = 1'b0;
    put(100, 50); chk("d1_transp_pix", {hit0, red0, green0, blue0}, 13'h0789);
    blank = 1'b1;
    put(101, 50);
    put(104, 50); chk("d1_blank_pix", {hit0, red0, green0, blue0}, 13'h0000);

    // x2 scale on u1 from (0,0)
    pos_x = 10'd0; pos_y = 10'd0;
    put(0, 0);
    put(2, 0); chk("d2_scale_x2", rom_address1, 12'd1);
    put(3, 0); chk("d2_scale_x3", rom_address1, 12'd1);
    bg_red = 4'h1; bg_green = 4'h2; bg_blue = 4'h3;
    put(64, 0); chk("d2_outside_addr", rom_address1, 12'd0);
    bg_red = 4'h0; bg_green = 4'h0; bg_blue = 4'h0;
    put(10, 10); put(10, 11); put(10, 12);
    chk("d2_outside_pix", {hit1, red1, green1, blue1}, 13'h0123);

    // animation on u1 (ANIM_DIV=2) from a clean reset, then clamped manual select
    Reset = 1'b1; tick(); Reset = 1'b0;
    anim_en = 1'b1;
    for (int k = 0; k < 9; k++) begin
      put(0, 0); chk("d3_anim_base", rom_address1, anim_exp[k]);
      put(5, 5);
    end
    anim_en = 1'b0; frame_sel = 4'd9;
    put(0, 0);
    chk("d3_clamp_u1", rom_address1, 12'd3072);
    chk("d3_clamp_u0", rom_address0, 12'd3072);

    // mid-frame position change only takes effect at the next frame start
    frame_sel = 4'd0; pos_x = 10'd100; pos_y = 10'd50;
    put(0, 0);
    pos_x = 10'd300;
    put(101, 51); chk("d4_old_pos", rom_address0, 12'd33);
    put(301, 51); chk("d4_new_pos_early", rom_address0, 12'd0);
    put(0, 0);
    put(301, 51); chk("d4_new_pos", rom_address0, 12'd33);

    // reset at row 200 while the sprite covers it
    pos_x = 10'd100; pos_y = 10'd190;
    put(0, 0);
    put(101, 201); chk("d5_before_reset", rom_address0, 12'd353);
    Reset = 1'b1;
    put(101, 201);
    chk("d5_reset_addr", rom_address0, 12'd0);
    chk("d5_reset_pix", {hit0, red0, green0, blue0}, 13'h0000);
    put(101, 201); put(101, 201);
    Reset = 1'b0;
    put(101, 201); chk("d5_absent", rom_address0, 12'd0);
    put(0, 0);
    put(101, 201); chk("d5_reappear", rom_address0, 12'd353);

    // randomized frames
    for (int f = 0; f < 40; f++) begin
      pos_x = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(560, 639)) : 10'($urandom_range(0, 639));
      pos_y = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(420, 479)) : 10'($urandom_range(0, 479));
      spr_en = ($urandom_range(0, 4) != 0);
      anim_en = ($urandom_range(0, 1) == 1);
      frame_sel = 4'($urandom_range(0, 15));
      blank = 1'b1;
      fx = int'(pos_x); fy = int'(pos_y);
      put(0, 0);
      for (int c = 0; c < 150; c++) begin
        if ($urandom_range(0, 19) == 0) begin
          pos_x = 10'($urandom_range(0, 639)); pos_y = 10'($urandom_range(0, 479));
          spr_en = ~spr_en; frame_sel = 4'($urandom_range(0, 15)); anim_en = ~anim_en;
        end
        if ($urandom_range(0, 4) == 0) begin
          x = int'($urandom_range(0, 799)); y = int'($urandom_range(0, 524));
        end else begin
          x = fx + int'($urandom_range(0, 80)) - 8;
          y = fy + int'($urandom_range(0, 80)) - 8;
          if (x < 0) x = 0;
          if (y < 0) y = 0;
        end
        blank = ($urandom_range(0, 9) != 0);
        bg_red = 4'($urandom_range(0, 15)); bg_green = 4'($urandom_range(0, 15)); bg_blue = 4'($urandom_range(0, 15));
        Reset = ($urandom_range(0, 299) == 0);
        put(x, y);
      end
      Reset = 1'b0;
    end

    repeat (6) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
